// File: rtl/contador_modular.sv
// contador_modular: parametrised up/down counter with a runtime limit,
// synchronous clear/load, wrap/saturate/one-shot modes and an enable prescaler.
// Optional compare-match output is built when CONTADOR_MODULAR_MATCH_EN is defined.
module contador_modular #(
  parameter int               WIDTH       = 8,
  parameter int               PRESCALE    = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             iCLOCK,
  input  logic             iRESET,
  input  logic             iCLEAR,
  input  logic             iENABLE,
  input  logic             iUP_DOWN,
  input  logic [1:0]       iMODE,
  input  logic             iLOAD,
  input  logic [WIDTH-1:0] iLOAD_VALUE,
  input  logic [WIDTH-1:0] iLIMIT,
  output logic [WIDTH-1:0] oCOUNT,
  output logic             oTC,
  output logic             oWRAP,
  output logic             oDONE
`ifdef CONTADOR_MODULAR_MATCH_EN
  ,
  input  logic [WIDTH-1:0] iCOMPARE,
  output logic             oMATCH
`endif
);

  // The prescaler must hold values 0..PRESCALE-1; a single bit is kept even
  // when PRESCALE=1 so the logic stays uniform.
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // Encoding 11 is deliberately decoded as wrap.
  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q, ps_d, ps_step;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             tick;
  logic             at_top;
  logic             above_top;
  logic             at_zero;

  assign mode      = mode_e'(iMODE);
  assign at_top    = (count_q >= iLIMIT);
  assign above_top = (count_q > iLIMIT);
  assign at_zero   = (count_q == '0);

  // Prescaler advance: frozen while a one-shot run is finished, ticks on its last phase.
  always_comb begin
    ps_step = ps_q;
    tick    = 1'b0;
    if (!done_q && iENABLE) begin
      if (ps_q == PS_LAST) begin
        tick    = 1'b1;
        ps_step = '0;
      end else begin
        ps_step = ps_q + 1'b1;
      end
    end
  end

  // Next-state selection: clear, then load, then a counting step, else hold.
  always_comb begin
    count_d = count_q;
    ps_d    = ps_step;
    wrap_d  = 1'b0;
    done_d  = done_q;
    if (iCLEAR) begin
      count_d = RESET_VALUE;
      ps_d    = '0;
      done_d  = 1'b0;
    end else if (iLOAD) begin
      count_d = (iLOAD_VALUE > iLIMIT) ? iLIMIT : iLOAD_VALUE;
      ps_d    = '0;
      done_d  = 1'b0;
    end else if (tick) begin
      if (iUP_DOWN) begin
        if (!at_top) begin
          count_d = count_q + 1'b1;
        end else begin
          case (mode)
            MODE_SAT: begin
              count_d = iLIMIT;
            end
            MODE_ONESHOT: begin
              count_d = iLIMIT;
              done_d  = 1'b1;
            end
            default: begin
              count_d = '0;
              wrap_d  = 1'b1;
            end
          endcase
        end
      end else begin
        if (above_top) begin
          count_d = iLIMIT;
        end else if (!at_zero) begin
          count_d = count_q - 1'b1;
        end else begin
          case (mode)
            MODE_SAT: begin
              count_d = count_q;
            end
            MODE_ONESHOT: begin
              count_d = count_q;
              done_d  = 1'b1;
            end
            default: begin
              count_d = iLIMIT;
              wrap_d  = 1'b1;
            end
          endcase
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      count_q <= RESET_VALUE;
      ps_q    <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

`ifdef CONTADOR_MODULAR_MATCH_EN
  logic match_q, match_d;

  // A match fires only when the count actually moves onto the compare value.
  always_comb begin
    match_d = 1'b0;
    if (!iCLEAR && (count_d != count_q) && (count_d == iCOMPARE)) begin
      match_d = 1'b1;
    end
  end

  // Match pulse register.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign oMATCH = match_q;
`endif

  assign oCOUNT = count_q;
  assign oWRAP  = wrap_q;
  assign oDONE  = done_q;
  assign oTC    = iUP_DOWN ? at_top : at_zero;

endmodule

// File: tb/tb_contador_modular.sv
// Scoreboard bench for contador_modular: one instance with PRESCALE=1 and one
// with PRESCALE=4 share the stimulus; each expectation names the instance it checks.
module tb_contador_modular;

  localparam logic [1:0] M_W = 2'b00;
  localparam logic [1:0] M_S = 2'b01;
  localparam logic [1:0] M_O = 2'b10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       ud = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       ld = 1'b0;
  logic [3:0] ldVal = 4'd0;
  logic [3:0] lim = 4'd5;
  logic [3:0] cmp = 4'hF;

  logic [3:0] countA, countB;
  logic       tcA, tcB, wrapA, wrapB, doneA, doneB;
  logic       matchA, matchB;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    string      name;
    int         sel;
    logic [3:0] count;
    logic       tc;
    logic       wrap;
    logic       done;
    logic       match;
  } exp_t;

  exp_t sbq[$];

  contador_modular #(.WIDTH(4), .PRESCALE(1), .RESET_VALUE(4'd0)) dutA (
    .iCLOCK(clock), .iRESET(reset), .iCLEAR(clr), .iENABLE(en),
    .iUP_DOWN(ud), .iMODE(mode), .iLOAD(ld), .iLOAD_VALUE(ldVal),
    .iLIMIT(lim), .oCOUNT(countA), .oTC(tcA), .oWRAP(wrapA), .oDONE(doneA)
`ifdef CONTADOR_MODULAR_MATCH_EN
    , .iCOMPARE(cmp), .oMATCH(matchA)
`endif
  );

  contador_modular #(.WIDTH(4), .PRESCALE(4), .RESET_VALUE(4'd0)) dutB (
    .iCLOCK(clock), .iRESET(reset), .iCLEAR(clr), .iENABLE(en),
    .iUP_DOWN(ud), .iMODE(mode), .iLOAD(ld), .iLOAD_VALUE(ldVal),
    .iLIMIT(lim), .oCOUNT(countB), .oTC(tcB), .oWRAP(wrapB), .oDONE(doneB)
`ifdef CONTADOR_MODULAR_MATCH_EN
    , .iCOMPARE(cmp), .oMATCH(matchB)
`endif
  );

`ifndef CONTADOR_MODULAR_MATCH_EN
  assign matchA = 1'b0;
  assign matchB = 1'b0;
`endif

  // Free-running clock.
  always #5 clock = ~clock;

  // Single comparison with failure reporting.
  task automatic checkOutput(input string name, input int act, input int expv);
    nChecks++;
    if (act != expv) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after that edge.
  task automatic applyStimulus(input string name, input logic r, input logic c,
                               input logic e, input logic u, input logic [1:0] m,
                               input logic l, input logic [3:0] lv, input logic [3:0] lm,
                               input int sel, input logic [3:0] ec, input logic etc,
                               input logic ew, input logic ed, input logic em);
    exp_t x;
    @(negedge clock);
    reset = r; clr = c; en = e; ud = u; mode = m; ld = l; ldVal = lv; lim = lm;
    @(posedge clock);
    x.name = name; x.sel = sel; x.count = ec; x.tc = etc;
    x.wrap = ew; x.done = ed; x.match = em;
    sbq.push_back(x);
  endtask

  // Monitor: pops one expectation per edge and compares against the chosen instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput({e.name, ".count"}, int'(e.sel ? countB : countA), int'(e.count));
        checkOutput({e.name, ".tc"},    int'(e.sel ? tcB : tcA),       int'(e.tc));
        checkOutput({e.name, ".wrap"},  int'(e.sel ? wrapB : wrapA),   int'(e.wrap));
        checkOutput({e.name, ".done"},  int'(e.sel ? doneB : doneA),   int'(e.done));
`ifdef CONTADOR_MODULAR_MATCH_EN
        checkOutput({e.name, ".match"}, int'(e.sel ? matchB : matchA), int'(e.match));
`endif
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus.
  initial begin
    logic [3:0] c;
    $display("[TB] starting contador_modular bench");

    applyStimulus("reset", 1, 0, 0, 1, M_W, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    applyStimulus("resetB", 0, 0, 0, 1, M_W, 0, 0, 5, 1, 0, 0, 0, 0, 0);

    // Wrap up, limit 5.
    for (int i = 0; i < 8; i++) begin
      c = 4'((i + 1) % 6);
      applyStimulus("wrapUp", 0, 0, 1, 1, M_W, 0, 0, 5, 0, c, c == 4'd5, c == 4'd0, 0, 0);
    end

    // Down wrap, limit 3, then clamped load and out-of-range recovery.
    applyStimulus("dnClear", 0, 1, 0, 0, M_W, 0, 0, 3, 0, 0, 1, 0, 0, 0);
    applyStimulus("dnWrap",  0, 0, 1, 0, M_W, 0, 0, 3, 0, 3, 0, 1, 0, 0);
    applyStimulus("ldClamp", 0, 0, 0, 0, M_W, 1, 9, 3, 0, 3, 0, 0, 0, 0);
    applyStimulus("dnRecov", 0, 0, 1, 0, M_W, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus("dnToZero", 0, 0, 1, 0, M_W, 0, 0, 1, 0, 0, 1, 0, 0, 0);

    // Saturate up, limit 2.
    applyStimulus("satClear", 0, 1, 0, 1, M_S, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    applyStimulus("sat1", 0, 0, 1, 1, M_S, 0, 0, 2, 0, 1, 0, 0, 0, 0);
    applyStimulus("sat2", 0, 0, 1, 1, M_S, 0, 0, 2, 0, 2, 1, 0, 0, 0);
    applyStimulus("sat3", 0, 0, 1, 1, M_S, 0, 0, 2, 0, 2, 1, 0, 0, 0);
    applyStimulus("sat4", 0, 0, 1, 1, M_S, 0, 0, 2, 0, 2, 1, 0, 0, 0);
    applyStimulus("sat5", 0, 0, 1, 1, M_S, 0, 0, 2, 0, 2, 1, 0, 0, 0);

    // Limit 0 in wrap mode: every tick wraps, count stays 0.
    applyStimulus("lim0a", 0, 0, 1, 1, M_W, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("lim0b", 0, 0, 1, 1, M_W, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("lim0hold", 0, 0, 0, 1, M_W, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // One-shot on the PRESCALE=4 instance, limit 3.
    applyStimulus("osClear", 0, 1, 0, 1, M_O, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 20; n++) begin
      c = (n / 4 >= 3) ? 4'd3 : 4'(n / 4);
      applyStimulus("oneShot", 0, 0, 1, 1, M_O, 0, 0, 3, 1, c, c == 4'd3, 0, n >= 16, 0);
    end
    applyStimulus("osLoad", 0, 0, 0, 1, M_O, 1, 1, 3, 1, 1, 0, 0, 0, 0);
    for (int n = 1; n <= 4; n++) begin
      applyStimulus("osResume", 0, 0, 1, 1, M_O, 0, 0, 3, 1, (n == 4) ? 4'd2 : 4'd1, 0, 0, 0, 0);
    end

    // Priority: reset+clear+load mid-count, then load beats a tick.
    applyStimulus("prClear", 0, 1, 0, 1, M_W, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus("prCount", 0, 0, 1, 1, M_W, 0, 0, 5, 0, 4'(i), 0, 0, 0, 0);
    end
    applyStimulus("prAll",  1, 1, 1, 1, M_W, 1, 2, 5, 0, 0, 0, 0, 0, 0);
    applyStimulus("prLoad", 0, 0, 1, 1, M_W, 1, 3, 5, 0, 3, 0, 0, 0, 0);
    applyStimulus("prTick", 0, 0, 1, 1, M_W, 0, 0, 5, 0, 4, 0, 0, 0, 0);

    // Compare match at 2; no repeat while holding.
    cmp = 4'd2;
    applyStimulus("mClear", 0, 1, 0, 1, M_W, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    applyStimulus("mStep1", 0, 0, 1, 1, M_W, 0, 0, 5, 0, 1, 0, 0, 0, 0);
    applyStimulus("mStep2", 0, 0, 1, 1, M_W, 0, 0, 5, 0, 2, 0, 0, 0, 1);
    applyStimulus("mHold1", 0, 0, 0, 1, M_W, 0, 0, 5, 0, 2, 0, 0, 0, 0);
    applyStimulus("mHold2", 0, 0, 0, 1, M_W, 0, 0, 5, 0, 2, 0, 0, 0, 0);

    @(posedge clock);
    #2;
    if (sbq.size() != 0) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
